// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue controller.
// FSM encoding, flag bit positions and the ALU opcode map.
package alu_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_ZERO  = 0;

    // Opcode map of the downstream ALU; the controller never decodes these.
    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_AND = 2;
    localparam int unsigned OP_OR  = 3;
    localparam int unsigned OP_XOR = 4;
    localparam int unsigned OP_SHL = 5;
    localparam int unsigned OP_SHR = 6;
    localparam int unsigned OP_ABS = 7;

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: two combinational read ports, two write ports.
// Write port 0 (writeback) wins over port 1 (load) on an index collision.
module alu_regfile #(
    parameter int unsigned N    = 8,
    parameter int unsigned REGS = 4,
    localparam int unsigned AW  = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_rd_addr0,
    output logic [N-1:0]  o_rd_data0,
    input  logic [AW-1:0] i_rd_addr1,
    output logic [N-1:0]  o_rd_data1,
    input  logic          i_we0,
    input  logic [AW-1:0] i_wa0,
    input  logic [N-1:0]  i_wd0,
    input  logic          i_we1,
    input  logic [AW-1:0] i_wa1,
    input  logic [N-1:0]  i_wd1
);

    logic [N-1:0] r_mem [REGS];

    assign o_rd_data0 = r_mem[i_rd_addr0];
    assign o_rd_data1 = r_mem[i_rd_addr1];

    // Port 0 is assigned last so it overrides port 1 on the same index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(REGS); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_we1) begin
                r_mem[i_wa1] <= i_wd1;
            end
            if (i_we0) begin
                r_mem[i_wa0] <= i_wd0;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller feeding a combinational ALU: operand read, result capture,
// writeback and a held response. Optional sticky carry via ALU_ISSUE_STICKY_CARRY_EN.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned REGS = 4,
    localparam int unsigned AW  = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_opcode,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [N-1:0]  ld_data,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [2:0]    alu_opcode,
    input  logic [N-1:0]  alu_result,
    input  logic [1:0]    alu_flags,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_result,
    output logic [1:0]    out_flags,
    output logic [AW-1:0] out_rd,
    output logic          sticky_carry,
    input  logic          sticky_clr
);

    state_t        r_state;
    logic          r_in_ready;
    logic [N-1:0]  r_alu_a;
    logic [N-1:0]  r_alu_b;
    logic [2:0]    r_alu_opcode;
    logic [AW-1:0] r_rd;
    logic          r_out_valid;
    logic [N-1:0]  r_out_result;
    logic [1:0]    r_out_flags;
    logic [AW-1:0] r_out_rd;

    logic [N-1:0]  w_rs1_data;
    logic [N-1:0]  w_rs2_data;
    logic          w_wb_en;

    assign w_wb_en = (r_state == ST_EXEC) && !rst;

    alu_regfile #(
        .N    (N),
        .REGS (REGS)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_rd_addr0 (in_rs1),
        .o_rd_data0 (w_rs1_data),
        .i_rd_addr1 (in_rs2),
        .o_rd_data1 (w_rs2_data),
        .i_we0      (w_wb_en),
        .i_wa0      (r_rd),
        .i_wd0      (alu_result),
        .i_we1      (ld_en),
        .i_wa1      (ld_addr),
        .i_wd1      (ld_data)
    );

    // in_ready is held low through the reset cycle and rises one edge later in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_rd         <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
            r_out_rd     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_alu_a      <= w_rs1_data;
                        r_alu_b      <= w_rs2_data;
                        r_alu_opcode <= in_opcode;
                        r_rd         <= in_rd;
                        r_in_ready   <= 1'b0;
                        r_state      <= ST_EXEC;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    r_out_result <= alu_result;
                    r_out_flags  <= alu_flags;
                    r_out_rd     <= r_rd;
                    r_out_valid  <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_opcode;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_flags  = r_out_flags;
    assign out_rd     = r_out_rd;

`ifdef ALU_ISSUE_STICKY_CARRY_EN
    logic r_sticky;

    // Clear takes priority over a same-cycle carry capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (sticky_clr) begin
            r_sticky <= 1'b0;
        end else if ((r_state == ST_EXEC) && alu_flags[FLAG_CARRY]) begin
            r_sticky <= 1'b1;
        end
    end

    assign sticky_carry = r_sticky;
`else
    logic w_unused_sticky_clr;

    assign w_unused_sticky_clr = sticky_clr;
    assign sticky_carry        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU stand-in.
module tb_alu_issue_ctrl;
    import alu_issue_pkg::*;

`ifdef ALU_ISSUE_STICKY_CARRY_EN
    localparam int STICKY_ON = 1;
`else
    localparam int STICKY_ON = 0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic [1:0] in_rd;
    logic [1:0] in_rs1;
    logic [1:0] in_rs2;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_result;
    logic [1:0] alu_flags;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [1:0] out_flags;
    logic [1:0] out_rd;
    logic       sticky_carry;
    logic       sticky_clr;

    int total;
    int bad;

    alu_issue_ctrl #(.N(8), .REGS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .out_rd       (out_rd),
        .sticky_carry (sticky_carry),
        .sticky_clr   (sticky_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: {carry, zero} flags, carry from ADD/SUB only.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum = '0;
        case (alu_opcode)
            3'd0:    alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1:    alu_sum = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2:    alu_sum = {1'b0, alu_a & alu_b};
            3'd3:    alu_sum = {1'b0, alu_a | alu_b};
            3'd4:    alu_sum = {1'b0, alu_a ^ alu_b};
            3'd5:    alu_sum = {1'b0, alu_a << 1};
            3'd6:    alu_sum = {1'b0, alu_a >> 1};
            default: alu_sum = {1'b0, alu_a[7] ? 8'(8'd0 - alu_a) : alu_a};
        endcase
        alu_result = alu_sum[7:0];
        alu_flags  = {alu_sum[8], alu_sum[7:0] == 8'd0};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int unsigned addr, input int unsigned data);
        ld_en   = 1'b1;
        ld_addr = 2'(addr);
        ld_data = 8'(data);
        tick();
        ld_en   = 1'b0;
    endtask

    // Offers an instruction, waits (bounded) for acceptance; returns in EXEC.
    task automatic issue_accept(input int unsigned op, input int unsigned rd,
                                input int unsigned rs1, input int unsigned rs2);
        int n;
        n         = 0;
        in_valid  = 1'b1;
        in_opcode = 3'(op);
        in_rd     = 2'(rd);
        in_rs1    = 2'(rs1);
        in_rs2    = 2'(rs2);
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("accept_wait", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("exec_out_valid", 32'(out_valid), 0);
        chk("exec_in_ready", 32'(in_ready), 0);
        chk("alu_opcode", 32'(alu_opcode), op);
    endtask

    // Clocks the EXEC edge, checks the response, then completes the handshake.
    task automatic finish_resp(input string tag, input int unsigned res,
                               input int unsigned flags, input int unsigned rd);
        tick();
        ld_en      = 1'b0;
        sticky_clr = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_result"}, 32'(out_result), res);
        chk({tag, "_flags"}, 32'(out_flags), flags);
        chk({tag, "_rd"}, 32'(out_rd), rd);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_done_valid"}, 32'(out_valid), 0);
        chk({tag, "_done_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_opcode  = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        ld_en      = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_result", 32'(out_result), 0);
        chk("rst_out_flags", 32'(out_flags), 0);
        chk("rst_out_rd", 32'(out_rd), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_b", 32'(alu_b), 0);
        chk("rst_alu_opcode", 32'(alu_opcode), 0);
        chk("rst_sticky", 32'(sticky_carry), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // Basic add: 05 + 03 -> R0 = 08
        load(1, 'h05);
        load(2, 'h03);
        issue_accept(OP_ADD, 0, 1, 2);
        chk("add_alu_a", 32'(alu_a), 'h05);
        chk("add_alu_b", 32'(alu_b), 'h03);
        finish_resp("add", 'h08, 0, 0);

        // Read back R0 through OR with rs1 == rs2; R3 = 08
        issue_accept(OP_OR, 3, 0, 0);
        chk("rd_r0_alu_a", 32'(alu_a), 'h08);
        finish_resp("rd_r0", 'h08, 0, 3);

        // Zero flag: 0F & F0 -> R2 = 00
        load(1, 'h0F);
        load(2, 'hF0);
        issue_accept(OP_AND, 2, 1, 2);
        finish_resp("and_zero", 'h00, 1, 2);

        // XOR: 3C ^ 0F = 33 -> R1
        load(1, 'h3C);
        load(2, 'h0F);
        issue_accept(OP_XOR, 1, 1, 2);
        finish_resp("xor", 'h33, 0, 1);

        // Back-pressure: 0F + 08 = 17, held while a new instruction is offered
        load(1, 'h0F);
        issue_accept(OP_ADD, 2, 1, 3);
        tick();
        in_valid  = 1'b1;
        in_opcode = 3'd7;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_result", 32'(out_result), 'h17);
            chk("bp_rd", 32'(out_rd), 2);
            chk("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        chk("bp_opcode_held", 32'(alu_opcode), OP_ADD);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 0);
        chk("bp_release_ready", 32'(in_ready), 1);

        // Write collision: writeback 08 to R3 beats a same-cycle load of AA
        load(1, 'h05);
        load(2, 'h03);
        load(3, 'h55);
        issue_accept(OP_ADD, 3, 1, 2);
        ld_en   = 1'b1;
        ld_addr = 2'd3;
        ld_data = 8'hAA;
        finish_resp("coll", 'h08, 0, 3);

        // Verify R3; a load to a different index in EXEC (R1 = 80) lands too
        issue_accept(OP_OR, 3, 3, 3);
        ld_en   = 1'b1;
        ld_addr = 2'd1;
        ld_data = 8'h80;
        finish_resp("coll_rd", 'h08, 0, 3);

        // Carry: 80 + 80 = 100 -> result 00, flags {1,1}
        load(2, 'h80);
        issue_accept(OP_ADD, 0, 1, 2);
        finish_resp("carry", 'h00, 3, 0);
        chk("sticky_set", 32'(sticky_carry), STICKY_ON);
        issue_accept(OP_OR, 1, 3, 3);
        finish_resp("no_carry", 'h08, 0, 1);
        chk("sticky_hold", 32'(sticky_carry), STICKY_ON);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("sticky_clr", 32'(sticky_carry), 0);

        // Clear wins over a same-cycle carry set: FF + FF = 1FE
        load(0, 'hFF);
        issue_accept(OP_ADD, 0, 0, 0);
        sticky_clr = 1'b1;
        finish_resp("clr_wins", 'hFE, 2, 0);
        chk("sticky_clr_wins", 32'(sticky_carry), 0);

        // Reset during EXEC drops the op; R0 returns to 0
        load(0, 'h11);
        issue_accept(OP_ADD, 0, 0, 0);
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk("midrst_alu_a", 32'(alu_a), 0);
        rst = 1'b0;
        tick();
        chk("midrst_after_ready", 32'(in_ready), 1);
        chk("midrst_after_valid", 32'(out_valid), 0);
        issue_accept(OP_OR, 1, 0, 0);
        finish_resp("midrst_r0", 'h00, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
